// File: rtl/vx_tex_dcr_bank_pkg.sv
// Texture DCR types, address map and field write/read helpers.
// Mip range follows TEX_LOD_MAX; optional readback uses TEX_DCR_READBACK_EN.
`ifndef TEX_LOD_MAX
`define TEX_LOD_MAX 3
`endif

package vx_tex_dcr_bank_pkg;

  localparam int LOD_MAX = `TEX_LOD_MAX;
  localparam int MIP_W   = 25;

  localparam logic [7:0] TEX_DCR_STAGE  = 8'd0;
  localparam logic [7:0] TEX_DCR_ADDR   = 8'd1;
  localparam logic [7:0] TEX_DCR_LOGDIM = 8'd2;
  localparam logic [7:0] TEX_DCR_FORMAT = 8'd3;
  localparam logic [7:0] TEX_DCR_FILTER = 8'd4;
  localparam logic [7:0] TEX_DCR_WRAP   = 8'd5;
  localparam logic [7:0] TEX_DCR_MIPOFF = 8'd6;
  localparam logic [7:0] TEX_DCR_COMMIT = 8'(7 + LOD_MAX);

  typedef enum logic [2:0] {
    FLD_NONE,
    FLD_ADDR,
    FLD_LOGDIM,
    FLD_FORMAT,
    FLD_FILTER,
    FLD_WRAP,
    FLD_MIPOFF
  } tex_dcr_field_e;

  typedef struct packed {
    logic [31:0]                  baddr;
    logic [3:0]                   logdim_v;
    logic [3:0]                   logdim_u;
    logic [2:0]                   format;
    logic [1:0]                   filter;
    logic [1:0]                   wrap_v;
    logic [1:0]                   wrap_u;
    logic [LOD_MAX:0][MIP_W-1:0]  mipoff;
  } tex_dcrs_t;

  function automatic tex_dcr_field_e dcr_field(
    input logic [7:0] a
  );
    tex_dcr_field_e f;
    unique case (1'b1)
      a == TEX_DCR_ADDR:   f = FLD_ADDR;
      a == TEX_DCR_LOGDIM: f = FLD_LOGDIM;
      a == TEX_DCR_FORMAT: f = FLD_FORMAT;
      a == TEX_DCR_FILTER: f = FLD_FILTER;
      a == TEX_DCR_WRAP:   f = FLD_WRAP;
      (a >= TEX_DCR_MIPOFF)
        && (a < TEX_DCR_COMMIT):
                           f = FLD_MIPOFF;
      default:             f = FLD_NONE;
    endcase
    return f;
  endfunction

  function automatic tex_dcrs_t dcr_write(
    input tex_dcrs_t      s,
    input tex_dcr_field_e f,
    input logic [7:0]     a,
    input logic [31:0]    d
  );
    tex_dcrs_t r;
    r = s;
    unique case (f)
      FLD_ADDR:   r.baddr = d;
      FLD_LOGDIM: begin
        r.logdim_v = d[19:16];
        r.logdim_u = d[3:0];
      end
      FLD_FORMAT: r.format = d[2:0];
      FLD_FILTER: r.filter = d[1:0];
      FLD_WRAP: begin
        r.wrap_v = d[17:16];
        r.wrap_u = d[1:0];
      end
      FLD_MIPOFF: begin
        for (int i = 0; i <= LOD_MAX; i++)
          if (a == 8'(TEX_DCR_MIPOFF + i))
            r.mipoff[i] = d[MIP_W-1:0];
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] dcr_read(
    input tex_dcrs_t  s,
    input logic [7:0] a
  );
    logic [31:0] v;
    v = '0;
    unique case (dcr_field(a))
      FLD_ADDR:   v = s.baddr;
      FLD_LOGDIM: v = {12'b0, s.logdim_v, 12'b0, s.logdim_u};
      FLD_FORMAT: v = {29'b0, s.format};
      FLD_FILTER: v = {30'b0, s.filter};
      FLD_WRAP:   v = {14'b0, s.wrap_v, 14'b0, s.wrap_u};
      FLD_MIPOFF: begin
        for (int i = 0; i <= LOD_MAX; i++)
          if (a == 8'(TEX_DCR_MIPOFF + i))
            v = 32'(s.mipoff[i]);
      end
      default: ;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vx_tex_dcr_bank_if.sv
// DCR write strobe plus texture-pipe req/rsp handshake.
// master drives writes and requests; slave is the DCR bank.
interface vx_tex_dcr_bank_if
  import vx_tex_dcr_bank_pkg::*;
#(
  parameter int STAGE_W = 2,
  parameter int TAG_W   = 8
) ();

  logic               dcr_wr_valid;
  logic [7:0]         dcr_wr_addr;
  logic [31:0]        dcr_wr_data;
  logic               req_valid;
  logic               req_ready;
  logic [STAGE_W-1:0] req_stage;
  logic [TAG_W-1:0]   req_tag;
  logic               rsp_valid;
  logic               rsp_ready;
  tex_dcrs_t          rsp_dcrs;
  logic [TAG_W-1:0]   rsp_tag;

  modport master (
    output dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
    output req_valid, req_stage, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_dcrs, rsp_tag
  );

  modport slave (
    input  dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
    input  req_valid, req_stage, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_dcrs, rsp_tag
  );

endinterface

// File: rtl/vx_tex_dcr_slot.sv
// One texture stage: shadow set written by the host, active set on commit.
// shadow port exists only with TEX_DCR_READBACK_EN.
module vx_tex_dcr_slot
  import vx_tex_dcr_bank_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           wr_en,
  input  tex_dcr_field_e wr_field,
  input  logic [7:0]     wr_addr,
  input  logic [31:0]    wr_data,
  input  logic           commit,
`ifdef TEX_DCR_READBACK_EN
  output tex_dcrs_t      shadow,
`endif
  output tex_dcrs_t      active
);

  tex_dcrs_t shd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shd    <= '0;
      active <= '0;
    end else begin
      if (wr_en)
        shd <= dcr_write(shd, wr_field, wr_addr, wr_data);
      if (commit)
        active <= shd;
    end
  end

`ifdef TEX_DCR_READBACK_EN
  assign shadow = shd;
`endif

endmodule

// File: rtl/vx_tex_dcr_bank.sv
// Multi-stage texture DCR bank: shadow/active sets per stage, 1-cycle reads.
// TEX_DCR_READBACK_EN adds rb_addr/rb_data shadow readback of cur_stage.
module vx_tex_dcr_bank
  import vx_tex_dcr_bank_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  vx_tex_dcr_bank_if.slave  bus
`ifdef TEX_DCR_READBACK_EN
  ,
  input  logic [7:0]        rb_addr,
  output logic [31:0]       rb_data
`endif
);

  localparam int STAGE_W =
    (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [STAGE_W-1:0] cur_stage;
  logic               cur_ok;
  tex_dcr_field_e     wr_field;
  logic               is_stage;
  logic               req_ready;
  logic               rsp_valid_q;
  tex_dcrs_t          rsp_dcrs_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  tex_dcrs_t          rd_dcrs;
  tex_dcrs_t          active [NUM_STAGES];
`ifdef TEX_DCR_READBACK_EN
  tex_dcrs_t          shadow [NUM_STAGES];
`endif

  assign wr_field = dcr_field(bus.dcr_wr_addr);
  assign is_stage = bus.dcr_wr_valid
                 && bus.dcr_wr_addr == TEX_DCR_STAGE;

  // Out-of-range stage values stay latched but gate all later writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_stage <= '0;
      cur_ok    <= 1'b1;
    end else if (is_stage) begin
      cur_stage <= bus.dcr_wr_data[STAGE_W-1:0];
      cur_ok    <= bus.dcr_wr_data < 32'(NUM_STAGES);
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_slot
    logic sel;
    assign sel = bus.dcr_wr_valid && cur_ok
              && (cur_stage == STAGE_W'(g));
    vx_tex_dcr_slot u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (sel && wr_field != FLD_NONE),
      .wr_field (wr_field),
      .wr_addr  (bus.dcr_wr_addr),
      .wr_data  (bus.dcr_wr_data),
      .commit   (sel && bus.dcr_wr_addr == TEX_DCR_COMMIT),
`ifdef TEX_DCR_READBACK_EN
      .shadow   (shadow[g]),
`endif
      .active   (active[g])
    );
  end

  always_comb begin
    rd_dcrs = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      if (bus.req_stage == STAGE_W'(i))
        rd_dcrs = active[i];
  end

  assign req_ready = !rsp_valid_q || bus.rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_dcrs_q  <= '0;
      rsp_tag_q   <= '0;
    end else if (bus.req_valid && req_ready) begin
      rsp_valid_q <= 1'b1;
      rsp_dcrs_q  <= rd_dcrs;
      rsp_tag_q   <= bus.req_tag;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dcrs  = rsp_dcrs_q;
  assign bus.rsp_tag   = rsp_tag_q;

`ifdef TEX_DCR_READBACK_EN
  always_comb begin
    rb_data = '0;
    if (rb_addr == TEX_DCR_STAGE)
      rb_data = 32'(cur_stage);
    else if (cur_ok)
      for (int i = 0; i < NUM_STAGES; i++)
        if (cur_stage == STAGE_W'(i))
          rb_data = dcr_read(shadow[i], rb_addr);
  end
`endif

endmodule
